// File: rtl/veririsc_pkg.sv
// Shared constants for the VeriRISC memory-side responder: controller phases,
// bus FSM states and protocol error codes.
package veririsc_pkg;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_HALT
    } bus_state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_RD_WR   = 3'd1;
    localparam logic [2:0] ERR_RD_DE   = 3'd2;
    localparam logic [2:0] ERR_WR_NODE = 3'd3;
    localparam logic [2:0] ERR_WR_SEL  = 3'd4;
    localparam logic [2:0] ERR_WPROT   = 3'd5;

endpackage

// File: rtl/mem_bus_responder_mem_array.sv
// Unified instruction/data memory: registered read with enable, one bus write
// port and one boot/debug write port that wins on an address collision.
module mem_array
    import veririsc_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  bus_we,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_wdata,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Storage is deliberately left without reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (bus_we && !(prog_we && (prog_addr == bus_addr))) begin
            mem[bus_addr] <= bus_wdata;
        end
        if (prog_we) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder to the VeriRISC controller strobes (sel, rd, wr, data_e).
// Define WRITE_PROTECT_EN to suppress bus writes below WP_LIMIT (error code 5).
module mem_bus_responder
    import veririsc_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 5,
    parameter int PHASE_WIDTH = 3
`ifdef WRITE_PROTECT_EN
    , parameter int WP_LIMIT  = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PHASE_WIDTH-1:0] phase,
    input  logic                   sel,
    input  logic                   rd,
    input  logic                   wr,
    input  logic                   data_e,
    input  logic                   halt,
    input  logic [ADDR_WIDTH-1:0]  pc_addr,
    input  logic [ADDR_WIDTH-1:0]  ir_addr,
    input  logic [DATA_WIDTH-1:0]  ac_data,
    input  logic                   prog_we,
    input  logic [ADDR_WIDTH-1:0]  prog_addr,
    input  logic [DATA_WIDTH-1:0]  prog_data,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   mem_valid,
    output logic [DATA_WIDTH-1:0]  bus_data,
    output logic                   proto_err,
    output logic [2:0]             err_code
);

    bus_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rd_en, bus_we;
    logic                  err_hit;
    logic [2:0]            err_code_d;
    logic                  addr_phase;

    assign addr_phase = (phase == PHASE_WIDTH'(PH_INST_ADDR)) ||
                        (phase == PHASE_WIDTH'(PH_OP_ADDR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (addr_phase && !halt) begin
            addr_q <= sel ? pc_addr : ir_addr;
        end
    end

    // Illegal strobe combinations, highest priority first; ignored while halted.
    always_comb begin
        err_code_d = ERR_NONE;
        if (!halt) begin
            if (rd && wr) begin
                err_code_d = ERR_RD_WR;
            end else if (rd && data_e) begin
                err_code_d = ERR_RD_DE;
            end else if (wr && !data_e) begin
                err_code_d = ERR_WR_NODE;
            end else if (wr && sel) begin
                err_code_d = ERR_WR_SEL;
`ifdef WRITE_PROTECT_EN
            end else if (wr && (32'(addr_q) < 32'(WP_LIMIT))) begin
                err_code_d = ERR_WPROT;
`endif
            end
        end
        err_hit = (err_code_d != ERR_NONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reads and writes fire only on the IDLE exit so a held strobe acts once.
    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        bus_we  = 1'b0;
        if (halt) begin
            state_d = S_HALT;
        end else if (err_hit) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rd) begin
                        state_d = S_READ;
                        rd_en   = 1'b1;
                    end else if (wr && data_e && !sel) begin
                        state_d = S_WRITE;
                        bus_we  = 1'b1;
                    end
                end
                S_READ:  if (!rd) state_d = S_IDLE;
                S_WRITE: if (!wr) state_d = S_IDLE;
                S_HALT:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err <= 1'b0;
            err_code  <= ERR_NONE;
        end else if (err_hit && !proto_err) begin
            proto_err <= 1'b1;
            err_code  <= err_code_d;
        end
    end

    assign mem_valid = (state_q == S_READ);
    assign bus_data  = data_e ? ac_data : (mem_valid ? rd_data : '0);

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk        (clk),
        .rst_n      (rst_n),
        .rd_en      (rd_en),
        .rd_addr    (addr_q),
        .bus_we     (bus_we),
        .bus_addr   (addr_q),
        .bus_wdata  (ac_data),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_data),
        .rd_data    (rd_data)
    );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a vector table for the fetch/store/
// error/halt flow plus hand sequences for reset, write protect and priority.
module tb_mem_bus_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] phase;
    logic       sel, rd, wr, data_e, halt;
    logic [4:0] pc_addr, ir_addr;
    logic [7:0] ac_data;
    logic       prog_we;
    logic [4:0] prog_addr;
    logic [7:0] prog_data;
    logic [7:0] rd_data;
    logic       mem_valid;
    logic [7:0] bus_data;
    logic       proto_err;
    logic [2:0] err_code;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] phase;
        logic       sel, rd, wr, data_e, halt;
        logic [4:0] pc_addr, ir_addr;
        logic [7:0] ac_data;
        logic       prog_we;
        logic [4:0] prog_addr;
        logic [7:0] prog_data;
        logic [7:0] exp_rd_data;
        logic       exp_valid;
        logic [7:0] exp_bus;
        logic       exp_err;
        logic [2:0] exp_code;
    } vec_t;

    vec_t vecs [29];

    always #5 clk = ~clk;

    mem_bus_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .phase     (phase),
        .sel       (sel),
        .rd        (rd),
        .wr        (wr),
        .data_e    (data_e),
        .halt      (halt),
        .pc_addr   (pc_addr),
        .ir_addr   (ir_addr),
        .ac_data   (ac_data),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .rd_data   (rd_data),
        .mem_valid (mem_valid),
        .bus_data  (bus_data),
        .proto_err (proto_err),
        .err_code  (err_code)
    );

    function automatic vec_t mk(
        input logic [2:0] ph, input logic s, input logic r, input logic w,
        input logic de, input logic h, input logic [4:0] pc, input logic [4:0] ir,
        input logic [7:0] ac, input logic pwe, input logic [4:0] pa, input logic [7:0] pd,
        input logic [7:0] e_rd, input logic e_v, input logic [7:0] e_bus,
        input logic e_err, input logic [2:0] e_code);
        vec_t v;
        v.phase = ph; v.sel = s; v.rd = r; v.wr = w; v.data_e = de; v.halt = h;
        v.pc_addr = pc; v.ir_addr = ir; v.ac_data = ac;
        v.prog_we = pwe; v.prog_addr = pa; v.prog_data = pd;
        v.exp_rd_data = e_rd; v.exp_valid = e_v; v.exp_bus = e_bus;
        v.exp_err = e_err; v.exp_code = e_code;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        phase     = v.phase;
        sel       = v.sel;
        rd        = v.rd;
        wr        = v.wr;
        data_e    = v.data_e;
        halt      = v.halt;
        pc_addr   = v.pc_addr;
        ir_addr   = v.ir_addr;
        ac_data   = v.ac_data;
        prog_we   = v.prog_we;
        prog_addr = v.prog_addr;
        prog_data = v.prog_data;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [7:0] e_rd, input logic e_v,
                            input logic [7:0] e_bus, input logic e_err, input logic [2:0] e_code);
        checkOutput({tag, ".rd_data"},   rd_data,          e_rd);
        checkOutput({tag, ".mem_valid"}, {7'd0, mem_valid}, {7'd0, e_v});
        checkOutput({tag, ".bus_data"},  bus_data,         e_bus);
        checkOutput({tag, ".proto_err"}, {7'd0, proto_err}, {7'd0, e_err});
        checkOutput({tag, ".err_code"},  {5'd0, err_code},  {5'd0, e_code});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        applyStimulus(mk(3'd3, 0, 0, 0, 0, 0, 5'd0, 5'd0, 8'h00, 0, 5'd0, 8'h00,
                         8'h00, 0, 8'h00, 0, 3'd0));
    endtask

    task automatic progWrite(input logic [4:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we   = 1'b0;
    endtask

    task automatic pulseReset();
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        idleInputs();
        rst_n = 1'b0;
        #3;
        checkAll("reset", 8'h00, 0, 8'h00, 0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        progWrite(5'd3, 8'hA5);
        progWrite(5'd7, 8'h11);
        progWrite(5'd2, 8'h22);
        progWrite(5'd0, 8'h44);
        idleInputs();

        //            ph   s  r  w  de h  pc     ir     ac    pwe pa     pd     rd    v  bus   e  code
        vecs[0]  = mk(3'd0, 1, 0, 0, 0, 0, 5'd3, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'h00, 0, 8'h00, 0, 3'd0);
        vecs[1]  = mk(3'd1, 1, 1, 0, 0, 0, 5'd3, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'hA5, 1, 8'hA5, 0, 3'd0);
        vecs[2]  = mk(3'd2, 1, 1, 0, 0, 0, 5'd3, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'hA5, 1, 8'hA5, 0, 3'd0);
        vecs[3]  = mk(3'd3, 0, 0, 0, 0, 0, 5'd0, 5'd0, 8'h00, 0, 5'd0, 8'h00, 8'hA5, 0, 8'h00, 0, 3'd0);
        vecs[4]  = mk(3'd4, 0, 0, 0, 0, 0, 5'd0, 5'd7, 8'h00, 0, 5'd0, 8'h00, 8'hA5, 0, 8'h00, 0, 3'd0);
        vecs[5]  = mk(3'd5, 0, 0, 0, 0, 0, 5'd0, 5'd7, 8'h00, 0, 5'd0, 8'h00, 8'hA5, 0, 8'h00, 0, 3'd0);
        vecs[6]  = mk(3'd6, 0, 0, 0, 1, 0, 5'd0, 5'd7, 8'h3C, 0, 5'd0, 8'h00, 8'hA5, 0, 8'h3C, 0, 3'd0);
        vecs[7]  = mk(3'd7, 0, 0, 1, 1, 0, 5'd0, 5'd7, 8'h3C, 0, 5'd0, 8'h00, 8'hA5, 0, 8'h3C, 0, 3'd0);
        vecs[8]  = mk(3'd7, 0, 0, 1, 1, 0, 5'd0, 5'd7, 8'h5A, 0, 5'd0, 8'h00, 8'hA5, 0, 8'h5A, 0, 3'd0);
        vecs[9]  = mk(3'd5, 0, 0, 0, 0, 0, 5'd0, 5'd7, 8'h00, 0, 5'd0, 8'h00, 8'hA5, 0, 8'h00, 0, 3'd0);
        vecs[10] = mk(3'd1, 0, 1, 0, 0, 0, 5'd0, 5'd7, 8'h00, 0, 5'd0, 8'h00, 8'h3C, 1, 8'h3C, 0, 3'd0);
        vecs[11] = mk(3'd2, 0, 0, 0, 0, 0, 5'd0, 5'd7, 8'h00, 0, 5'd0, 8'h00, 8'h3C, 0, 8'h00, 0, 3'd0);
        vecs[12] = mk(3'd0, 0, 0, 0, 0, 0, 5'd0, 5'd2, 8'h00, 0, 5'd0, 8'h00, 8'h3C, 0, 8'h00, 0, 3'd0);
        vecs[13] = mk(3'd1, 0, 1, 0, 1, 0, 5'd0, 5'd2, 8'h77, 0, 5'd0, 8'h00, 8'h3C, 0, 8'h77, 1, 3'd2);
        vecs[14] = mk(3'd5, 0, 0, 1, 0, 0, 5'd0, 5'd2, 8'h00, 0, 5'd0, 8'h00, 8'h3C, 0, 8'h00, 1, 3'd2);
        vecs[15] = mk(3'd1, 0, 1, 0, 0, 0, 5'd0, 5'd2, 8'h00, 0, 5'd0, 8'h00, 8'h22, 1, 8'h22, 1, 3'd2);
        vecs[16] = mk(3'd2, 0, 1, 0, 0, 1, 5'd0, 5'd2, 8'h00, 0, 5'd0, 8'h00, 8'h22, 0, 8'h00, 1, 3'd2);
        vecs[17] = mk(3'd7, 0, 0, 1, 1, 1, 5'd0, 5'd2, 8'h99, 1, 5'd0, 8'h6B, 8'h22, 0, 8'h99, 1, 3'd2);
        vecs[18] = mk(3'd3, 0, 0, 0, 0, 0, 5'd0, 5'd2, 8'h00, 0, 5'd0, 8'h00, 8'h22, 0, 8'h00, 1, 3'd2);
        vecs[19] = mk(3'd1, 0, 1, 0, 0, 0, 5'd0, 5'd2, 8'h00, 0, 5'd0, 8'h00, 8'h22, 1, 8'h22, 1, 3'd2);
        vecs[20] = mk(3'd2, 0, 0, 0, 0, 0, 5'd0, 5'd2, 8'h00, 0, 5'd0, 8'h00, 8'h22, 0, 8'h00, 1, 3'd2);
        vecs[21] = mk(3'd0, 1, 0, 0, 0, 0, 5'd0, 5'd2, 8'h00, 0, 5'd0, 8'h00, 8'h22, 0, 8'h00, 1, 3'd2);
        vecs[22] = mk(3'd1, 1, 1, 0, 0, 0, 5'd0, 5'd2, 8'h00, 0, 5'd0, 8'h00, 8'h6B, 1, 8'h6B, 1, 3'd2);
        vecs[23] = mk(3'd2, 0, 0, 0, 0, 0, 5'd0, 5'd2, 8'h00, 0, 5'd0, 8'h00, 8'h6B, 0, 8'h00, 1, 3'd2);
        vecs[24] = mk(3'd4, 0, 0, 0, 0, 0, 5'd0, 5'd7, 8'h00, 0, 5'd0, 8'h00, 8'h6B, 0, 8'h00, 1, 3'd2);
        vecs[25] = mk(3'd7, 0, 0, 1, 1, 0, 5'd0, 5'd7, 8'hE1, 1, 5'd7, 8'h0F, 8'h6B, 0, 8'hE1, 1, 3'd2);
        vecs[26] = mk(3'd5, 0, 0, 0, 0, 0, 5'd0, 5'd7, 8'h00, 0, 5'd0, 8'h00, 8'h6B, 0, 8'h00, 1, 3'd2);
        vecs[27] = mk(3'd1, 0, 1, 0, 0, 0, 5'd0, 5'd7, 8'h00, 0, 5'd0, 8'h00, 8'h0F, 1, 8'h0F, 1, 3'd2);
        vecs[28] = mk(3'd2, 0, 0, 0, 0, 0, 5'd0, 5'd7, 8'h00, 0, 5'd0, 8'h00, 8'h0F, 0, 8'h00, 1, 3'd2);

        for (int i = 0; i < 29; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkAll($sformatf("vec%0d", i), vecs[i].exp_rd_data, vecs[i].exp_valid,
                     vecs[i].exp_bus, vecs[i].exp_err, vecs[i].exp_code);
        end

        // Reset asserted while a read burst is active clears outputs immediately.
        idleInputs();
        phase = 3'd1;
        rd    = 1'b1;
        step();
        checkOutput("midread.valid_before", {7'd0, mem_valid}, 8'h01);
        rst_n = 1'b0;
        #1;
        checkAll("midread.reset", 8'h00, 0, 8'h00, 0, 3'd0);
        rd = 1'b0;
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Bus write to address 2: lands by default, suppressed with write protect.
        idleInputs();
        phase = 3'd4; ir_addr = 5'd2;
        step();
        phase = 3'd7; wr = 1'b1; data_e = 1'b1; ac_data = 8'hC3;
        step();
`ifdef WRITE_PROTECT_EN
        checkOutput("wprot.err",  {7'd0, proto_err}, 8'h01);
        checkOutput("wprot.code", {5'd0, err_code},  8'h05);
`else
        checkOutput("wprot.err",  {7'd0, proto_err}, 8'h00);
        checkOutput("wprot.code", {5'd0, err_code},  8'h00);
`endif
        wr = 1'b0; data_e = 1'b0; phase = 3'd5;
        step();
        phase = 3'd1; rd = 1'b1;
        step();
`ifdef WRITE_PROTECT_EN
        checkOutput("wprot.rdback", rd_data, 8'h22);
`else
        checkOutput("wprot.rdback", rd_data, 8'hC3);
`endif
        rd = 1'b0; phase = 3'd2;
        step();

        // rd&wr outranks rd&data_e; a later wr&sel does not overwrite the code.
        pulseReset();
        idleInputs();
        phase = 3'd1; rd = 1'b1; wr = 1'b1; data_e = 1'b1;
        step();
        checkAll("prio.rdwr", 8'h00, 0, 8'h00 | ac_data, 1, 3'd1);
        phase = 3'd5; rd = 1'b0; sel = 1'b1;
        step();
        checkOutput("prio.sticky_code", {5'd0, err_code}, 8'h01);
        checkOutput("prio.sticky_err",  {7'd0, proto_err}, 8'h01);
        idleInputs();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Memory-side responder to the VeriRISC sequencing controller's bus strobes (sel, rd, wr, data_e).
- Latches the address during address phases and serves registered reads for instruction and operand fetch.
- Commits accumulator writes for STO and flags illegal strobe combinations.
- Sits between the controller, PC, IR operand field and accumulator, and owns the unified instruction/data memory.

Parameters:
- DATA_WIDTH, 8, memory word and bus width.
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH.
- PHASE_WIDTH, 3, width of the phase input.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- phase  input  PHASE_WIDTH  current controller phase 0..7.
- sel  input  1  1 = instruction address (pc_addr); 0 = operand address (ir_addr).
- rd  input  1  memory read enable.
- wr  input  1  memory write strobe.
- data_e  input  1  accumulator drives the bus.
- halt  input  1  machine halted.
- pc_addr  input  ADDR_WIDTH  program counter.
- ir_addr  input  ADDR_WIDTH  IR operand field.
- ac_data  input  DATA_WIDTH  accumulator value.
- prog_we  input  1  boot/debug write enable.
- prog_addr  input  ADDR_WIDTH  boot/debug write address.
- prog_data  input  DATA_WIDTH  boot/debug write data.
- rd_data  output  DATA_WIDTH  registered read data.
- mem_valid  output  1  rd_data valid for the current rd burst.
- bus_data  output  DATA_WIDTH  resolved data bus.
- proto_err  output  1  sticky protocol error.
- err_code  output  3  code of the first error.

Behaviour:
- Reset (async, rst_n=0): rd_data=0, mem_valid=0, addr_q=0, proto_err=0, err_code=0, FSM=S_IDLE. Memory contents are not reset.
- Address latch: on each edge with phase[1:0]==0 (phases 0 and 4) and halt=0, addr_q <= sel ? pc_addr : ir_addr. addr_q holds in all other phases.
- FSM states: S_IDLE, S_READ, S_WRITE, S_HALT.
- S_IDLE -> S_READ on rd=1 (and wr=0, halt=0):
  - RAM is read at addr_q.
  - rd_data updates at that edge; mem_valid=1 from the next cycle (1-cycle latency).
  - Example: rd in phase 1 gives data valid in phase 2, when ld_ir samples it.
- S_READ: rd_data and mem_valid hold while rd=1. No re-read, even if addr_q changes. rd=0 -> S_IDLE, with mem_valid cleared at that edge.
- S_IDLE -> S_WRITE on wr=1, data_e=1, rd=0, sel=0: mem[addr_q] <= ac_data, once.
- S_WRITE: further wr cycles do not rewrite. wr=0 -> S_IDLE.
- Any state -> S_HALT on halt=1. In S_HALT: rd and wr are ignored, mem_valid=0, rd_data holds. halt=0 -> S_IDLE.
- prog_we:
  - Writes mem[prog_addr] <= prog_data in any state, including S_HALT.
  - Same-cycle wr to the same address is dropped, with no error.
  - prog_we does not change the FSM state.
- bus_data = data_e ? ac_data : (mem_valid ? rd_data : 0). Combinational.
- Error detection, evaluated every edge with halt=0, priority order:
  - code 1: rd&wr.
  - code 2: rd&data_e.
  - code 3: wr&!data_e.
  - code 4: wr&sel.
- Error handling:
  - The offending cycle performs no read and no write; FSM stays or returns to S_IDLE.
  - proto_err sets and stays set; err_code captures only the first error.
  - Both clear only on reset.
- Reset mid-read or mid-write: outputs clear immediately. A write on the same edge as reset assertion is not guaranteed.

Optional Feature:
- Macro: WRITE_PROTECT_EN.
- Defined:
  - Adds parameter WP_LIMIT (default 16). A wr (not prog_we) to an address below WP_LIMIT is suppressed.
  - Raises proto_err with err_code=5, at lowest priority after codes 1–4.
- Undefined: no write-protect check; code 5 is never produced.

Decomposition:
- Package veririsc_pkg holds:
  - phase constants PH_INST_ADDR..PH_STORE (0..7).
  - FSM state enum (S_IDLE, S_READ, S_WRITE, S_HALT).
  - err_code constants ERR_NONE=0, ERR_RD_WR=1, ERR_RD_DE=2, ERR_WR_NODE=3, ERR_WR_SEL=4, ERR_WPROT=5.
- One sub-module, mem_array: synchronous single-port read plus two write ports, DATA_WIDTH x 2**ADDR_WIDTH, registered read with enable, prog port priority.

Test Plan:
- Instruction fetch: prog_we mem[3]=8'hA5; pc_addr=3, phase 0 sel=1, phase 1 rd=1 -> phase 2: rd_data=8'hA5, mem_valid=1, bus_data=8'hA5.
- Store: ir_addr=7, ac_data=8'h3C, phase 4 latch, phase 6-7 data_e=1, phase 7 wr=1 -> mem[7]=8'h3C; subsequent read of 7 returns 8'h3C; only one write.
- Contention: rd=1, data_e=1 same cycle -> proto_err=1, err_code=2, no read; later wr&!data_e leaves err_code=2.
- Halt: halt=1 during rd -> mem_valid=0 next cycle; wr ignored, mem unchanged; prog_we to addr 0 still writes.
- Reset mid-read: rst_n=0 while mem_valid=1 -> rd_data=0, mem_valid=0 immediately, err cleared.
- WRITE_PROTECT_EN: wr to addr 2 with WP_LIMIT=16 -> mem[2] unchanged, err_code=5; without the macro the write lands.
